// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: frame layout,
// command codes and FSM state encoding.
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TURN  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    function automatic logic [FRAME_W-1:0] mk_frame(
        input logic [1:0]        cmd,
        input logic [DATA_W-1:0] payload
    );
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serializer / deserializer for the SPI RAM master.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_i, frame_i     parallel load of a 10-bit frame
//   shift_en_i          advance the serializer by one bit
//   tx_bit_o            current MSB of the serializer
//   sample_en_i         shift rx_bit_i into the deserializer
//   rx_bit_i            serial input (MISO)
//   rx_byte_o           stored bits plus the bit being sampled now
module spi_shift_reg
    import spi_ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               shift_en_i,
    output logic               tx_bit_o,
    input  logic               sample_en_i,
    input  logic               rx_bit_i,
    output logic [DATA_W-1:0]  rx_byte_o
);

    logic [FRAME_W-1:0] tx_q, tx_d;
    // Only 7 bits are stored: the 8th arrives on the capture edge
    // itself and is appended combinationally in rx_byte_o.
    logic [DATA_W-2:0]  rx_q, rx_d;

    always_comb begin
        tx_d = tx_q;
        if (load_i) begin
            tx_d = frame_i;
        end else if (shift_en_i) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
        rx_d = rx_q;
        if (sample_en_i) begin
            rx_d = {rx_q[DATA_W-3:0], rx_bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    assign tx_bit_o  = tx_q[FRAME_W-1];
    assign rx_byte_o = {rx_q, rx_bit_i};

endmodule

// File: rtl/spi_ram_master.sv
// SPI master turning host read/write requests into address and
// data frames for the SPI-slave RAM wrapper; SPI runs on clk.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          host request handshake
//   req_wr, req_addr, req_wdata  request fields (captured at accept)
//   rsp_valid, rsp_rdata         read response pulse / held read byte
//   busy                         transaction in progress
//   SS_n, MOSI, MISO             SPI bus
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int PRE_CYC = 2,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] PRE_LD  = 4'(PRE_CYC - 1);
    localparam logic [3:0] BIT_LD  = 4'(FRAME_W - 1);
    localparam logic [3:0] TURN_LD = 4'(RD_LAT - 1);
    localparam logic [3:0] RECV_LD = 4'(DATA_W - 1);
    localparam logic [3:0] GAP_LD  = 4'(GAP_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              second_q, second_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic               load;
    logic               shift_en;
    logic               sample_en;
    logic [FRAME_W-1:0] load_frame;
    logic [FRAME_W-1:0] first_frame;
    logic [FRAME_W-1:0] second_frame;
    logic               tx_bit;
    logic [DATA_W-1:0]  rx_byte;

    // The address frame is built from the live request because it
    // must be loaded on the accepting edge itself.
    assign first_frame = mk_frame(req_wr ? CMD_WR_ADDR : CMD_RD_ADDR,
                                  req_addr);
    assign second_frame = mk_frame(wr_q ? CMD_WR_DATA : CMD_RD_DATA,
                                   wr_q ? wdata_q : '0);

    spi_shift_reg u_shift (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .frame_i     (load_frame),
        .shift_en_i  (shift_en),
        .tx_bit_o    (tx_bit),
        .sample_en_i (sample_en),
        .rx_bit_i    (MISO),
        .rx_byte_o   (rx_byte)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        second_d    = second_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        load        = 1'b0;
        load_frame  = first_frame;
        shift_en    = 1'b0;
        sample_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d     = req_wr;
                    wdata_d  = req_wdata;
                    second_d = 1'b0;
                    load     = 1'b1;
                    ss_n_d   = 1'b0;
                    mosi_d   = first_frame[FRAME_W-1];
                    cnt_d    = PRE_LD;
                    state_d  = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt_q == 4'd0) begin
                    // MSB goes out again for the first shift cycle.
                    mosi_d   = tx_bit;
                    shift_en = 1'b1;
                    cnt_d    = BIT_LD;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 4'd0) begin
                    mosi_d = 1'b0;
                    if (second_q && !wr_q) begin
                        if (RD_LAT == 0) begin
                            cnt_d   = RECV_LD;
                            state_d = ST_RECV;
                        end else begin
                            cnt_d   = TURN_LD;
                            state_d = ST_TURN;
                        end
                    end else begin
                        ss_n_d  = 1'b1;
                        cnt_d   = GAP_LD;
                        state_d = ST_GAP;
                    end
                end else begin
                    mosi_d   = tx_bit;
                    shift_en = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = RECV_LD;
                    state_d = ST_RECV;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECV: begin
                sample_en = 1'b1;
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_byte;
                    ss_n_d      = 1'b1;
                    cnt_d       = GAP_LD;
                    state_d     = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    if (second_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        second_d   = 1'b1;
                        load       = 1'b1;
                        load_frame = second_frame;
                        ss_n_d     = 1'b0;
                        mosi_d     = second_frame[FRAME_W-1];
                        cnt_d      = PRE_LD;
                        state_d    = ST_PRE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            second_q    <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            second_q    <= second_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master with a behavioural
// SPI-slave RAM model and frame/timing reference.
module tb_spi_ram_master;
    import spi_ram_pkg::*;

    localparam int PRE    = 2;
    localparam int RDL    = 1;
    localparam int GAP    = 1;
    localparam int SEG_S  = PRE + 10;
    localparam int SEG_RD = PRE + 10 + RDL + 8;
    localparam int RSTART = PRE + 10 + RDL;
    localparam int LAT_WR = 2 * (PRE + 10 + GAP);
    localparam int LAT_RD = LAT_WR + RDL + 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy, SS_n, MOSI, MISO;

    always #5 clk = ~clk;

    spi_ram_master #(
        .PRE_CYC (PRE),
        .RD_LAT  (RDL),
        .GAP_CYC (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         len;
        logic [9:0] frame;
        bit         pre_ok;
        bit         tail_zero;
    } seg_t;

    logic [7:0] sl_ram  [256];
    logic [7:0] exp_ram [256];
    logic [7:0] sl_waddr = 8'h00;
    logic [7:0] sl_raddr = 8'h00;
    logic [7:0] last_rd  = 8'h00;
    bit         seg_bits [$];
    seg_t       segs [$];
    int         gaps [$];
    int         hi_len = 0;

    // Slave model: records each SS_n-low segment, decodes frames,
    // drives MISO during the receive window of a read-data frame.
    always @(negedge clk) begin
        int   c;
        seg_t s;
        if (SS_n === 1'b0) begin
            if (seg_bits.size() == 0) begin
                gaps.push_back(hi_len);
                hi_len = 0;
            end
            seg_bits.push_back(MOSI);
            c = seg_bits.size() - 1;
            if (c >= RSTART && c < RSTART + 8
                && seg_bits[PRE] && seg_bits[PRE+1])
                MISO = sl_ram[sl_raddr][7 - (c - RSTART)];
            else
                MISO = 1'($urandom);
        end else begin
            if (seg_bits.size() != 0) begin
                s.len = seg_bits.size();
                s.frame = '0;
                s.pre_ok = 1'b1;
                s.tail_zero = 1'b1;
                for (int i = 0; i < PRE; i++)
                    if (i < s.len && seg_bits[i] != seg_bits[PRE])
                        s.pre_ok = 1'b0;
                for (int i = 0; i < 10; i++)
                    if (PRE + i < s.len)
                        s.frame[9-i] = seg_bits[PRE+i];
                for (int i = PRE + 10; i < s.len; i++)
                    if (seg_bits[i]) s.tail_zero = 1'b0;
                if (s.len >= SEG_S) begin
                    case (s.frame[9:8])
                        2'b00:   sl_waddr = s.frame[7:0];
                        2'b01:   sl_ram[sl_waddr] = s.frame[7:0];
                        2'b10:   sl_raddr = s.frame[7:0];
                        default: ;
                    endcase
                end
                segs.push_back(s);
                seg_bits.delete();
            end
            hi_len++;
            MISO = 1'($urandom);
        end
    end

    // Issues one request from a negedge; returns at a negedge.
    // inj: cycle to pulse a stray write to 0xFF; rst_at: cycle to
    // assert rst (returns right after the reset edge).
    task automatic run_txn(
        input  bit         wr,
        input  logic [7:0] a,
        input  logic [7:0] d,
        input  bit         keep,
        input  int         inj,
        input  int         rst_at,
        output int         lat,
        output int         nrsp,
        output logic [7:0] rd,
        output bit         to
    );
        int w;
        w = 0;
        to = 1'b0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) to = 1'b1;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        lat = 0;
        nrsp = 0;
        rd = 8'h00;
        do begin
            if (inj >= 0 && lat == inj) begin
                req_valid = 1'b1;
                req_wr = 1'b1;
                req_addr = 8'hFF;
                req_wdata = 8'($urandom);
            end
            if (inj >= 0 && lat == inj + 1) req_valid = 1'b0;
            if (lat == rst_at) rst = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                nrsp++;
                rd = rsp_rdata;
            end
            if (lat - 1 == rst_at) break;
        end while (req_ready !== 1'b1 && lat < 200);
        if (req_ready !== 1'b1) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({SS_n, req_ready, busy, rsp_valid, MOSI, rsp_rdata}
                !== {5'b11000, 8'h00}) begin
                errors++;
                $display("FAIL reset cyc=%0d ss=%b rdy=%b busy=%b rv=%b mosi=%b rd=%h want 1 1 0 0 0 00",
                         k, SS_n, req_ready, busy, rsp_valid, MOSI, rsp_rdata);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] a, d, rd;
        logic [9:0] ef [2];
        int lat, nrsp;
        bit to;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 8'h5A : 8'($urandom_range(0, 254));
            d = (k == 0) ? 8'hC3 : 8'($urandom);
            ef[0] = {CMD_WR_ADDR, a};
            ef[1] = {CMD_WR_DATA, d};
            segs.delete();
            gaps.delete();
            run_txn(1'b1, a, d, 1'b0, -1, -1, lat, nrsp, rd, to);
            exp_ram[a] = d;
            checks++;
            if (to || lat != LAT_WR) begin
                errors++;
                $display("FAIL wr_lat a=%h got %0d want %0d to=%b",
                         a, lat, LAT_WR, to);
            end
            checks++;
            if (segs.size() != 2) begin
                errors++;
                $display("FAIL wr_nseg got %0d want 2", segs.size());
            end else begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (segs[i].frame !== ef[i] || segs[i].len != SEG_S
                        || !segs[i].pre_ok || !segs[i].tail_zero) begin
                        errors++;
                        $display("FAIL wr_frame%0d got %b len %0d pre %b tail %b want %b len %0d",
                                 i, segs[i].frame, segs[i].len, segs[i].pre_ok,
                                 segs[i].tail_zero, ef[i], SEG_S);
                    end
                end
                checks++;
                if (gaps[1] != GAP) begin
                    errors++;
                    $display("FAIL wr_gap got %0d want %0d", gaps[1], GAP);
                end
            end
            checks++;
            if (sl_ram[a] !== exp_ram[a] || nrsp != 0) begin
                errors++;
                $display("FAIL wr_ram a=%h got %h rsp %0d want %h rsp 0",
                         a, sl_ram[a], nrsp, exp_ram[a]);
            end
            checks++;
            if (rsp_rdata !== last_rd) begin
                errors++;
                $display("FAIL wr_hold got %h want %h", rsp_rdata, last_rd);
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] a, rd;
        logic [9:0] ef [2];
        int el [2];
        int lat, nrsp;
        bit to;
        sl_ram[8'h3C] = 8'hA5;
        exp_ram[8'h3C] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 8'h3C : 8'($urandom_range(0, 254));
            ef[0] = {CMD_RD_ADDR, a};
            ef[1] = {CMD_RD_DATA, 8'h00};
            el[0] = SEG_S;
            el[1] = SEG_RD;
            segs.delete();
            gaps.delete();
            run_txn(1'b0, a, 8'($urandom), 1'b0, -1, -1, lat, nrsp, rd, to);
            checks++;
            if (to || lat != LAT_RD) begin
                errors++;
                $display("FAIL rd_lat a=%h got %0d want %0d to=%b",
                         a, lat, LAT_RD, to);
            end
            checks++;
            if (nrsp != 1 || rd !== exp_ram[a]) begin
                errors++;
                $display("FAIL rd_data a=%h got %h x%0d want %h x1",
                         a, rd, nrsp, exp_ram[a]);
            end
            last_rd = exp_ram[a];
            checks++;
            if (segs.size() != 2) begin
                errors++;
                $display("FAIL rd_nseg got %0d want 2", segs.size());
            end else begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (segs[i].frame !== ef[i] || segs[i].len != el[i]
                        || !segs[i].pre_ok || !segs[i].tail_zero) begin
                        errors++;
                        $display("FAIL rd_frame%0d got %b len %0d pre %b tail %b want %b len %0d",
                                 i, segs[i].frame, segs[i].len, segs[i].pre_ok,
                                 segs[i].tail_zero, ef[i], el[i]);
                    end
                end
                checks++;
                if (gaps[1] != GAP) begin
                    errors++;
                    $display("FAIL rd_gap got %0d want %0d", gaps[1], GAP);
                end
            end
            checks++;
            if (rsp_rdata !== last_rd) begin
                errors++;
                $display("FAIL rd_hold got %h want %h", rsp_rdata, last_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        int lat, nrsp;
        bit to;
        int eg [4];
        eg[1] = GAP;
        eg[2] = GAP + 1;
        eg[3] = GAP;
        segs.delete();
        gaps.delete();
        run_txn(1'b1, 8'h10, 8'h7E, 1'b1, -1, -1, lat, nrsp, rd, to);
        exp_ram[8'h10] = 8'h7E;
        checks++;
        if (to || lat != LAT_WR) begin
            errors++;
            $display("FAIL b2b_wr_lat got %0d want %0d", lat, LAT_WR);
        end
        run_txn(1'b0, 8'h10, 8'h00, 1'b0, -1, -1, lat, nrsp, rd, to);
        checks++;
        if (to || lat != LAT_RD || nrsp != 1 || rd !== 8'h7E) begin
            errors++;
            $display("FAIL b2b_rd lat %0d rsp %0d data %h want %0d 1 7e",
                     lat, nrsp, rd, LAT_RD);
        end
        last_rd = 8'h7E;
        checks++;
        if (gaps.size() != 4 || segs.size() != 4) begin
            errors++;
            $display("FAIL b2b_nseg got %0d/%0d want 4/4",
                     gaps.size(), segs.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (gaps[i] != eg[i]) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got %0d want %0d",
                             i, gaps[i], eg[i]);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] a, d, fv, rd;
        int lat, nrsp;
        bit to;
        fv = 8'($urandom);
        sl_ram[8'hFF] = fv;
        exp_ram[8'hFF] = fv;
        a = 8'($urandom_range(0, 254));
        d = 8'($urandom);
        segs.delete();
        run_txn(1'b1, a, d, 1'b0, PRE + 4, -1, lat, nrsp, rd, to);
        exp_ram[a] = d;
        checks++;
        if (to || lat != LAT_WR || segs.size() != 2) begin
            errors++;
            $display("FAIL busy_wr lat %0d nseg %0d want %0d 2",
                     lat, segs.size(), LAT_WR);
        end
        segs.delete();
        run_txn(1'b0, a, 8'h00, 1'b0, PRE + 4, -1, lat, nrsp, rd, to);
        checks++;
        if (to || lat != LAT_RD || nrsp != 1 || rd !== d
            || segs.size() != 2) begin
            errors++;
            $display("FAIL busy_rd lat %0d rsp %0d data %h nseg %0d want %0d 1 %h 2",
                     lat, nrsp, rd, segs.size(), LAT_RD, d);
        end
        last_rd = d;
        repeat (4) @(negedge clk);
        checks++;
        if (sl_ram[8'hFF] !== fv || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ff got %h rdy %b want %h 1",
                     sl_ram[8'hFF], req_ready, fv);
        end
    endtask

    task automatic test_abort();
        logic [7:0] v, rd;
        int lat, nrsp, late;
        bit to;
        v = 8'($urandom);
        sl_ram[8'h22] = v;
        exp_ram[8'h22] = v;
        run_txn(1'b0, 8'h22, 8'h00, 1'b0, -1,
                2 * (PRE + 10) + GAP + RDL + 3, lat, nrsp, rd, to);
        checks++;
        if (nrsp != 0 || {SS_n, req_ready, busy, rsp_valid, MOSI, rsp_rdata}
            !== {5'b11000, 8'h00}) begin
            errors++;
            $display("FAIL abort_rst rsp %0d ss=%b rdy=%b busy=%b rv=%b mosi=%b rd=%h want 0 1 1 0 0 0 00",
                     nrsp, SS_n, req_ready, busy, rsp_valid, MOSI, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd = 8'h00;
        late = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) late++;
        end
        checks++;
        if (late != 0 || SS_n !== 1'b1 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL abort_quiet rsp %0d ss %b rd %h want 0 1 00",
                     late, SS_n, rsp_rdata);
        end
        run_txn(1'b0, 8'h22, 8'h00, 1'b0, -1, -1, lat, nrsp, rd, to);
        checks++;
        if (to || lat != LAT_RD || nrsp != 1 || rd !== v) begin
            errors++;
            $display("FAIL abort_reread lat %0d rsp %0d data %h want %0d 1 %h",
                     lat, nrsp, rd, LAT_RD, v);
        end
        last_rd = v;
    endtask

    task automatic test_random();
        logic [7:0] a, d, rd;
        bit wr, to;
        int lat, nrsp;
        for (int k = 0; k < 12; k++) begin
            wr = 1'($urandom);
            a = 8'($urandom_range(0, 7));
            d = 8'($urandom);
            run_txn(wr, a, d, 1'b0, -1, -1, lat, nrsp, rd, to);
            if (wr) exp_ram[a] = d;
            checks++;
            if (to || lat != (wr ? LAT_WR : LAT_RD)
                || nrsp != (wr ? 0 : 1)
                || (!wr && rd !== exp_ram[a])) begin
                errors++;
                $display("FAIL rand%0d wr=%b a=%h lat %0d rsp %0d data %h want %0d %0d %h",
                         k, wr, a, lat, nrsp, rd,
                         wr ? LAT_WR : LAT_RD, wr ? 0 : 1, exp_ram[a]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = 8'h00;
        req_wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            sl_ram[i] = 8'($urandom);
            exp_ram[i] = sl_ram[i];
        end
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
